ring_arbiter: RTL

//  Round-robin arbiter sharing one resource between N requesters, using a one-hot

---
 rtl/ring_arb_pkg.sv | 40 ++++
 rtl/ring_arbiter_if.sv | 39 +++
 rtl/ring_prio_pick.sv | 53 +++++
 rtl/ring_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ring_arb_pkg.sv
// rtl/ring_arb_pkg.sv - shared types and helpers for the ring arbiter
// Purpose: FSM state enum, index-width helpers and one-hot to binary conversion.
// Ports: none (package).
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Widest vector the one-hot helper accepts; N must not exceed this.
    localparam int MAX_N = 32;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single requester still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // ORing the positions of set bits is exact for one-hot input and gives 0 for 0.
    function automatic int unsigned onehot_to_idx(input logic [MAX_N-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (v[i]) begin
                idx = idx | unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ring_arbiter_if.sv
// rtl/ring_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Purpose: groups the arbiter's request and grant signals.
// Ports (signals): mode, req[N] toward arbiter; grant[N], grant_valid,
//   grant_idx[IDX_W], ptr[N], timeout_pulse from arbiter.
// Modports: master = requester side, slave = arbiter side.
interface ring_arbiter_if #(
    parameter int N     = 8,
    parameter int IDX_W = ring_arb_pkg::idx_w(N)
) ();

    logic             mode;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic [N-1:0]     ptr;
    logic             timeout_pulse;

    modport master (
        output mode,
        output req,
        input  grant,
        input  grant_valid,
        input  grant_idx,
        input  ptr,
        input  timeout_pulse
    );

    modport slave (
        input  mode,
        input  req,
        output grant,
        output grant_valid,
        output grant_idx,
        output ptr,
        output timeout_pulse
    );

endinterface

// File: rtl/ring_prio_pick.sv
// rtl/ring_prio_pick.sv - combinational round-robin winner selection
// Purpose: picks the first requester after the ptr token in the mode direction.
// Ports: req[N] in, ptr[N] in (one-hot token), mode in (0 toward MSB, 1 toward LSB),
//   winner[N] out (one-hot, zero when req is zero).
module ring_prio_pick
    import ring_arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    input  logic         mode,
    output logic [N-1:0] winner
);

    localparam logic [N-1:0] ONE = N'(1);

    // Physical bit reached after stepping 'off' places from 'start' in scan direction.
    function automatic int ring_pos(input int start, input int off, input logic m);
        return m ? ((start - off + N) % N) : ((start + off) % N);
    endfunction

    logic         ptr_ok;
    int           base;
    int           start;
    logic [N-1:0] rot;
    logic         found;

    always_comb begin
        // A corrupted token (zero or multi-hot) is read as bit0.
        ptr_ok = (ptr != '0) && ((ptr & (ptr - ONE)) == '0);
        base   = ptr_ok ? int'(onehot_to_idx(MAX_N'(ptr))) : 0;

        // The token holder's neighbour gets top priority; the holder itself comes last.
        start = mode ? ((base + N - 1) % N) : ((base + 1) % N);

        // Rotate so the scan start sits at rot[0], then pick the lowest set bit.
        rot = '0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[ring_pos(start, i, mode)];
        end

        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                winner[ring_pos(start, i, mode)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ring_arbiter.sv
// rtl/ring_arbiter.sv - round-robin arbiter with one-hot ring pointer token
// Purpose: shares one resource between N requesters; registered one-hot grant.
// Ports: clk (rising edge), rst (synchronous, active-low),
//   bus (ring_arbiter_if.slave): mode, req in; grant, grant_valid, grant_idx,
//   ptr, timeout_pulse out.
// Build option: RING_ARB_TIMEOUT_EN adds a hold counter forcing release after
//   MAX_HOLD consecutive grant cycles; otherwise timeout_pulse is tied 0.
module ring_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    ring_arbiter_if.slave  bus
);

    localparam int           IDX_W = idx_w(N);
    localparam logic [N-1:0] ONE   = N'(1);

    // Parameter sanity: an empty block, present only so bad values are visible here.
    if (N < 2 || N > MAX_N || MAX_HOLD < 1) begin : g_param_out_of_range
    end

    state_t       state_q, state_d;
    logic [N-1:0] grant_q, grant_d;
    logic [N-1:0] ptr_q,   ptr_d;
    logic [N-1:0] winner;

`ifdef RING_ARB_TIMEOUT_EN
    localparam int HOLD_W = idx_w(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    ring_prio_pick #(
        .N (N)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .mode   (bus.mode),
        .winner (winner)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= ONE;
`ifdef RING_ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
`ifdef RING_ARB_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef RING_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req != '0) begin
                    grant_d = winner;
                    ptr_d   = winner;
                    state_d = GRANT;
`ifdef RING_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                // Release always passes through IDLE, giving the one-cycle bubble.
                if ((bus.req & grant_q) == '0) begin
                    grant_d = '0;
                    state_d = IDLE;
                end
`ifdef RING_ARB_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    // ptr keeps the owner so it ranks last in the next round.
                    grant_d   = '0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
`endif
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus.grant       = grant_q;
        bus.grant_valid = |grant_q;
        bus.grant_idx   = IDX_W'(onehot_to_idx(MAX_N'(grant_q)));
        bus.ptr         = ptr_q;
`ifdef RING_ARB_TIMEOUT_EN
        bus.timeout_pulse = timeout_q;
`else
        bus.timeout_pulse = 1'b0;
`endif
    end

endmodule
